// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, frame config payload.
package uart_pkg;

    // Transmit/receive FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // parity_mode encodings; the fourth code behaves like PAR_NONE
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Per-frame line configuration captured when a frame is launched
    typedef struct packed {
        logic [1:0] parity_mode;
        logic       two_stop;
    } frame_cfg_t;

    // True when the mode inserts a parity bit
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Parity bit from the XOR of the data bits; odd mode inverts it
    function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
        return data_xor ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and full/empty flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nx;
    logic             do_push;
    logic             do_pop;

    // Requests against a full or empty FIFO are ignored
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Occupancy after this cycle; push and pop together cancel out
    always_comb begin
        count_nx = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointers, count and flags; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nx;
            full  <= (count_nx == CNT_W'(DEPTH));
            empty <= (count_nx == '0);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from a TX FIFO; frame settings are latched per frame.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DBIT  = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DIV_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       divisor,
    input  logic [1:0]             parity_mode,
    input  logic                   two_stop,
    input  logic                   wr_valid,
    input  logic [DBIT-1:0]        wr_data,
    output logic                   wr_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   tx
);

    localparam int unsigned IDX_W = $clog2(DBIT);

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [DBIT-1:0]  fifo_data;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DBIT-1:0]  data_q, data_d;
    logic [DIV_W-1:0] div_q, div_d;
    frame_cfg_t       cfg_q, cfg_d;
    logic             tx_d;
    logic             last_tick;
    logic             start_ok;
    logic             launch;

    assign wr_ready  = !fifo_full;
    assign fifo_push = wr_valid && !fifo_full;

    sync_fifo #(
        .WIDTH (DBIT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Final cycle of the current bit period, and permission to launch a frame
    assign last_tick = (cnt_q == div_q - DIV_W'(1));
    assign start_ok  = enable && !fifo_empty;

    // Next-state, bit timing, frame launch and next tx level
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + DIV_W'(1);
        idx_d    = idx_q;
        data_d   = data_q;
        div_d    = div_q;
        cfg_d    = cfg_q;
        launch   = 1'b0;
        fifo_pop = 1'b0;
        tx_d     = 1'b1;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_ok) begin
                    launch = 1'b1;
                end
            end
            ST_START: begin
                if (last_tick) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_tick) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(DBIT - 1)) begin
                        idx_d   = '0;
                        state_d = parity_enabled(cfg_q.parity_mode) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (last_tick) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (last_tick) begin
                    cnt_d = '0;
                    if (cfg_q.two_stop && (idx_q == '0)) begin
                        idx_d = IDX_W'(1);
                    end else if (start_ok) begin
                        launch = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Pop the head word and capture everything the frame depends on
        if (launch) begin
            fifo_pop          = 1'b1;
            data_d            = fifo_data;
            div_d             = (divisor == '0) ? DIV_W'(1) : divisor;
            cfg_d.parity_mode = parity_mode;
            cfg_d.two_stop    = two_stop;
            cnt_d             = '0;
            idx_d             = '0;
            state_d           = ST_START;
        end

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_d[idx_d];
            ST_PARITY: tx_d = parity_bit(cfg_d.parity_mode, ^data_d);
            default:   tx_d = 1'b1;
        endcase
    end

    // State, frame context and registered line outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            div_q   <= DIV_W'(1);
            cfg_q   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            div_q   <= div_d;
            cfg_q   <= cfg_d;
            tx      <= tx_d;
            busy    <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writes queue expected frames, a monitor checks tx.
module tb_uart_tx_fifo;

    localparam int unsigned DBIT  = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DIV_W = 16;

    logic                   clock;
    logic                   reset;
    logic                   enable;
    logic [DIV_W-1:0]       divisor;
    logic [1:0]             parity_mode;
    logic                   two_stop;
    logic                   wr_valid;
    logic [DBIT-1:0]        wr_data;
    logic                   wr_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   busy;
    logic                   tx;

    uart_tx_fifo #(
        .DBIT  (DBIT),
        .DEPTH (DEPTH),
        .DIV_W (DIV_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .divisor     (divisor),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .tx          (tx)
    );

    // Expected frame: bits[0] is the start bit, in line order
    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          div;
        bit          follow;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b1;
    bit   mon_active = 1'b0;
    int   frame_no = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [11:0] bits, input int nbits, input int div, input bit follow);
        exp_t e;
        e.bits   = bits;
        e.nbits  = nbits;
        e.div    = div;
        e.follow = follow;
        sb.push_back(e);
    endtask

    // No parity, one stop bit: start 0, data LSB first, stop 1
    function automatic logic [11:0] plain_frame(input logic [7:0] d);
        return {2'b00, 1'b1, d, 1'b0};
    endfunction

    task automatic do_write(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(posedge clock);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0 && !mon_active) begin
                done = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        check({name, "_drain"}, 32'(done), 32'd1);
    endtask

    // Monitor: decode each frame from tx and compare to the scoreboard head
    initial begin : monitor
        exp_t        e;
        bit          chained;
        int          errs;
        logic [11:0] act;
        chained = 1'b0;
        forever begin
            if (!chained) begin
                do @(negedge clock); while (!(mon_en && tx === 1'b0));
            end
            chained = 1'b0;
            if (sb.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
                while (tx === 1'b0) @(negedge clock);
                continue;
            end
            mon_active = 1'b1;
            e = sb.pop_front();
            frame_no++;
            errs = 0;
            act  = '0;
            for (int b = 0; b < e.nbits; b++) begin
                for (int c = 0; c < e.div; c++) begin
                    if (b != 0 || c != 0) @(negedge clock);
                    if (tx !== e.bits[b] || busy !== 1'b1) errs++;
                    if (c == e.div / 2) act[b] = tx;
                end
            end
            n_tests++;
            if (errs != 0) begin
                n_fail++;
                $display("FAIL frame%0d: tx bits 0x%0h expected 0x%0h, %0d bad cycles",
                         frame_no, act, e.bits, errs);
            end
            @(negedge clock);
            if (e.follow) begin
                check($sformatf("frame%0d_next_start", frame_no), {30'd0, busy, tx}, 32'b10);
                chained = (tx === 1'b0);
            end else begin
                check($sformatf("frame%0d_idle_after", frame_no), {30'd0, busy, tx}, 32'b01);
            end
            if (!chained) mon_active = 1'b0;
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] burst [16];
        int         bad;
        bit         seen;

        burst = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                  8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

        reset       = 1'b1;
        enable      = 1'b0;
        divisor     = 16'd4;
        parity_mode = 2'd0;
        two_stop    = 1'b0;
        wr_valid    = 1'b0;
        wr_data     = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // 0xA5, divisor 4, no parity, one stop
        enable = 1'b1;
        expect_frame(12'h34A, 10, 4, 1'b0);
        do_write(8'hA5);
        check("a5_count_after_write", 32'(fifo_count), 32'd1);
        wait_drain("a5", 200);

        // Parity cases
        parity_mode = 2'd1;
        expect_frame(12'h60E, 11, 4, 1'b0);
        do_write(8'h07);
        wait_drain("even07", 200);
        parity_mode = 2'd2;
        expect_frame(12'h40E, 11, 4, 1'b0);
        do_write(8'h07);
        wait_drain("odd07", 200);
        expect_frame(12'h600, 11, 4, 1'b0);
        do_write(8'h00);
        wait_drain("odd00", 200);

        // Two stop bits, divisor 3, divisor changed mid-frame
        parity_mode = 2'd0;
        two_stop    = 1'b1;
        divisor     = 16'd3;
        expect_frame(12'h600, 11, 3, 1'b0);
        do_write(8'h00);
        repeat (10) @(posedge clock);
        #1;
        divisor = 16'd7;
        wait_drain("two_stop", 200);
        two_stop = 1'b0;

        // Fill FIFO while disabled, overflow write dropped, then back-to-back drain
        divisor = 16'd2;
        enable  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expect_frame(plain_frame(burst[i]), 10, 2, (i != 15));
            do_write(burst[i]);
        end
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_count", 32'(fifo_count), 32'd16);
        do_write(8'h5E);
        check("overflow_count", 32'(fifo_count), 32'd16);
        check("overflow_wr_ready", 32'(wr_ready), 32'd0);
        enable = 1'b1;
        wait_drain("burst", 600);

        // Reset during DATA bit 3 aborts the frame and flushes the FIFO
        mon_en  = 1'b0;
        divisor = 16'd4;
        do_write(8'h5A);
        do_write(8'hC3);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        check("abort_start_seen", 32'(seen), 32'd1);
        repeat (17) @(posedge clock);
        #1;
        check("abort_bit3_tx", 32'(tx), 32'd1);
        check("abort_bit3_busy", 32'(busy), 32'd1);
        reset    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        wr_valid = 1'b0;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(fifo_count), 32'd0);
        check("abort_wr_ready", 32'(wr_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("abort_quiet_cycles", 32'(bad), 32'd0);
        mon_en = 1'b1;

        // Divisor 0 behaves as 1
        divisor = 16'd0;
        expect_frame(12'h278, 10, 1, 1'b0);
        do_write(8'h3C);
        wait_drain("div0", 100);

        // Simultaneous write and pop at count 5
        enable  = 1'b0;
        divisor = 16'd1;
        for (int i = 0; i < 5; i++) begin
            expect_frame(plain_frame(burst[i + 3]), 10, 1, 1'b1);
            do_write(burst[i + 3]);
        end
        check("pre_pop_count", 32'(fifo_count), 32'd5);
        enable = 1'b1;
        expect_frame(plain_frame(8'h81), 10, 1, 1'b0);
        do_write(8'h81);
        check("push_pop_count", 32'(fifo_count), 32'd5);
        wait_drain("push_pop", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame, legal 5..8.
REQ-002 SHALL have parameter DEPTH, default 16, TX FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter DIV_W, default 16, width of the baud divisor.
REQ-004 SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  permits starting new frames.
REQ-007 SHALL have port divisor  in  DIV_W  clock cycles per bit.
REQ-008 SHALL have port parity_mode  in  2  0 none, 1 even, 2 odd, 3 treated as none.
REQ-009 SHALL have port two_stop  in  1  0 one stop bit, 1 two stop bits.
REQ-010 SHALL have port wr_valid  in  1  write request.
REQ-011 SHALL have port wr_data  in  DBIT  byte to queue.
REQ-012 SHALL have port wr_ready  out  1  FIFO can accept a write.
REQ-013 SHALL have port fifo_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port busy  out  1  frame in progress.
REQ-015 SHALL have port tx  out  1  serial line, idle high.

Function
REQ-016 SHALL accept a write on a cycle when wr_valid and wr_ready are both high; wr_ready = (fifo_count != DEPTH).
REQ-017 SHALL drop writes while full, with no state change; no overflow flag.
REQ-018 SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL leave IDLE when enable is high and the FIFO is non-empty: pop the head entry, enter START, and drive tx=0 from the next cycle.
REQ-020 SHALL, at the pop, latch the popped byte, divisor, parity_mode and two_stop; changes mid-frame SHALL have no effect.
REQ-021 SHALL hold each bit for max(divisor,1) cycles; divisor 0 behaves as 1.
REQ-022 SHALL shift DATA LSB first, DBIT bits.
REQ-023 SHALL skip PARITY when the latched mode is none or 3; even sends XOR of the data bits, odd sends its inverse.
REQ-024 SHALL drive STOP high for 1 or 2 bit periods.
REQ-025 SHALL, at the end of STOP, start the next frame immediately (no idle cycle) when enable is high and the FIFO is non-empty, else go to IDLE.
REQ-026 SHALL let a frame in progress finish when enable drops; only new frame starts are blocked.
REQ-027 SHALL let a word written into an empty FIFO be popped no earlier than the following cycle.
REQ-028 SHALL apply a simultaneous accepted write and pop together: fifo_count unchanged, data order preserved.
REQ-029 SHALL wrap read and write pointers modulo DEPTH.
REQ-030 SHALL assert busy in every state except IDLE.
REQ-031 SHALL register tx, so it is glitch-free, and drive it high in IDLE.
REQ-032 SHALL give a frame total of (1+DBIT+P+S)*max(divisor,1) cycles; P is 0 or 1, S is 1 or 2.

Reset
REQ-033 SHALL, on reset, go to IDLE, set tx=1, busy=0, fifo_count=0 and wr_ready=1 at the next edge.
REQ-034 SHALL, on reset mid-frame, abort the frame (tx high the next cycle) and flush the FIFO; no partial resume.
REQ-035 SHALL ignore wr_valid during reset.

Structure
REQ-036 SHALL place the state encoding and parity_mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) in shared package uart_pkg.
REQ-037 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, count), reusable by the future RX path.
REQ-038 SHALL keep the bit-period counter and bit index in uart_tx_fifo.

Verification
REQ-039 SHALL verify: DBIT=8, divisor=4, no parity, 1 stop; write 0xA5 -> tx 0,1,0,1,0,0,1,0,1,1 at 4 cycles each, 40 cycles, busy high throughout.
REQ-040 SHALL verify: even parity, write 0x07 -> parity bit 1; odd parity, 0x07 -> 0; odd parity, 0x00 -> 1.
REQ-041 SHALL verify: enable=0, write DEPTH=16 words -> wr_ready low after the 16th; 17th write dropped; enable=1 -> 16 back-to-back frames, no idle gap, data in order.
REQ-042 SHALL verify: two_stop=1, divisor=3, write 0x00 -> stop held 6 cycles; divisor changed mid-frame -> current frame still 3 cycles per bit.
REQ-043 SHALL verify: reset asserted during DATA bit 3 -> next cycle tx=1, busy=0, fifo_count=0; no further frame.
REQ-044 SHALL verify: divisor=0 -> 1 cycle per bit; a write on the same cycle as a pop while count=5 -> count stays 5.
